// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
// Deserialises an I2S ADC stream from a codec that is bit-clock and LR-clock master.
// Output is 16-bit signed PCM in the i_clk domain: one o_sample_valid pulse per stereo
// frame, plus a saturating count of framing errors.
// Optional build macro I2S_RX_MONO_MIX_EN: o_sample_out is the floor average of L and R.
// Without it, o_sample_out follows the left word.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | not capturing, waiting for lrck fall with enable high
// S_SKIP_L  | lrck fell, waiting out the I2S one-bit delay before left MSB
// S_SHIFT_L | shifting left-slot bits, MSB first
// S_WAIT_R  | left word complete, waiting for lrck rise
// S_SKIP_R  | lrck rose, waiting out the one-bit delay before right MSB
// S_SHIFT_R | shifting right-slot bits, MSB first
// S_EMIT    | outputs just loaded, sample_valid high for this cycle
// S_WAIT_L  | frame done, waiting for the next lrck fall
module i2s_adc_receiver #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_aud_bclk,
    input  logic                  i_aud_adclrck,
    input  logic                  i_aud_adcdat,
    output logic [DATA_WIDTH-1:0] o_left_sample,
    output logic [DATA_WIDTH-1:0] o_right_sample,
    output logic [DATA_WIDTH-1:0] o_sample_out,
    output logic                  o_sample_valid,
    output logic                  o_frame_err,
    output logic [7:0]            o_err_count
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP_L,
        S_SHIFT_L,
        S_WAIT_R,
        S_SKIP_R,
        S_SHIFT_R,
        S_EMIT,
        S_WAIT_L
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lrck_s1, r_lrck_s2, r_lrck_s3;
    logic r_dat_s1, r_dat_s2;

    logic w_bclk_rise;
    logic w_lrck_rise;
    logic w_lrck_fall;
    logic w_dat;

    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift_l;
    // The right LSB is taken straight from the pin path on the EMIT transition,
    // so only DATA_WIDTH-1 bits need holding here.
    logic [DATA_WIDTH-2:0] r_shift_r;

    logic [DATA_WIDTH-1:0] w_right_word;
    logic [DATA_WIDTH-1:0] w_mono;
    logic                  w_last;

    logic w_shift_l;
    logic w_shift_r;
    logic w_cnt_clr;
    logic w_load;
    logic w_err;

    logic [DATA_WIDTH-1:0] r_left_sample;
    logic [DATA_WIDTH-1:0] r_right_sample;
    logic [DATA_WIDTH-1:0] r_sample_out;
    logic                  r_sample_valid;
    logic                  r_frame_err;
    logic [7:0]            r_err_count;

    // Two-flop synchronisers for the codec pins, plus a third stage on bclk/lrck for edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_s3 <= 1'b0;
            r_lrck_s1 <= 1'b0;
            r_lrck_s2 <= 1'b0;
            r_lrck_s3 <= 1'b0;
            r_dat_s1  <= 1'b0;
            r_dat_s2  <= 1'b0;
        end else begin
            r_bclk_s1 <= i_aud_bclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_s3 <= r_bclk_s2;
            r_lrck_s1 <= i_aud_adclrck;
            r_lrck_s2 <= r_lrck_s1;
            r_lrck_s3 <= r_lrck_s2;
            r_dat_s1  <= i_aud_adcdat;
            r_dat_s2  <= r_dat_s1;
        end
    end

    assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_s3;
    assign w_lrck_rise  = r_lrck_s2 & ~r_lrck_s3;
    assign w_lrck_fall  = ~r_lrck_s2 & r_lrck_s3;
    assign w_dat        = r_dat_s2;
    assign w_last       = (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_right_word = {r_shift_r, w_dat};

`ifdef I2S_RX_MONO_MIX_EN
    assign w_mono = DATA_WIDTH'(($signed({r_shift_l[DATA_WIDTH-1], r_shift_l})
                               + $signed({w_right_word[DATA_WIDTH-1], w_right_word})) >>> 1);
`else
    assign w_mono = r_shift_l;
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes; an lrck edge always wins over a coincident bclk rise,
    // and that bclk rise is consumed as the one-bit delay slot
    always_comb begin
        w_state_next = r_state;
        w_shift_l    = 1'b0;
        w_shift_r    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_load       = 1'b0;
        w_err        = 1'b0;

        if (r_state != S_IDLE && !i_enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lrck_fall && i_enable) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = w_bclk_rise ? S_SHIFT_L : S_SKIP_L;
                    end
                end
                S_SKIP_L: begin
                    if (w_bclk_rise) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = S_SHIFT_L;
                    end
                end
                S_SHIFT_L, S_SHIFT_R: begin
                    if (w_lrck_fall) begin
                        w_err        = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = w_bclk_rise ? S_SHIFT_L : S_SKIP_L;
                    end else if (w_lrck_rise) begin
                        w_err        = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_bclk_rise) begin
                        if (r_state == S_SHIFT_L) begin
                            w_shift_l = 1'b1;
                            if (w_last) begin
                                w_state_next = S_WAIT_R;
                            end
                        end else begin
                            w_shift_r = 1'b1;
                            if (w_last) begin
                                w_load       = 1'b1;
                                w_state_next = S_EMIT;
                            end
                        end
                    end
                end
                S_WAIT_R: begin
                    if (w_lrck_fall) begin
                        w_err        = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = w_bclk_rise ? S_SHIFT_L : S_SKIP_L;
                    end else if (w_lrck_rise) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = w_bclk_rise ? S_SHIFT_R : S_SKIP_R;
                    end
                end
                S_SKIP_R: begin
                    if (w_bclk_rise) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = S_SHIFT_R;
                    end
                end
                S_EMIT: begin
                    w_state_next = S_WAIT_L;
                end
                S_WAIT_L: begin
                    if (w_lrck_fall) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = w_bclk_rise ? S_SHIFT_L : S_SKIP_L;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Bit counter and per-channel shift registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_l || w_shift_r) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            if (w_shift_l) begin
                r_shift_l <= {r_shift_l[DATA_WIDTH-2:0], w_dat};
            end
            if (w_shift_r) begin
                r_shift_r <= {r_shift_r[DATA_WIDTH-3:0], w_dat};
            end
        end
    end

    // Sample outputs load together with the valid pulse and hold until the next frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= w_load;
            if (w_load) begin
                r_left_sample  <= r_shift_l;
                r_right_sample <= w_right_word;
                r_sample_out   <= w_mono;
            end
        end
    end

    // Framing error pulse and saturating error counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_frame_err <= w_err;
            if (w_err && r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_left_sample  = r_left_sample;
    assign o_right_sample = r_right_sample;
    assign o_sample_out   = r_sample_out;
    assign o_sample_valid = r_sample_valid;
    assign o_frame_err    = r_frame_err;
    assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: drives I2S frames as the codec would and checks the
// captured words, valid timing and error counting against a frame-level model.
module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        aud_bclk = 1'b0;
    logic        aud_adclrck = 1'b1;
    logic        aud_adcdat = 1'b0;
    logic [15:0] left_sample, right_sample, sample_out;
    logic        sample_valid, frame_err;
    logic [7:0]  err_count;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int half = 8;
    int last_rise_cyc = 0;
    int n_err_pulse = 0;
    int exp_err = 0;

    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    logic [15:0] q_o[$];
    int          q_cyc[$];

    i2s_adc_receiver dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_aud_bclk     (aud_bclk),
        .i_aud_adclrck  (aud_adclrck),
        .i_aud_adcdat   (aud_adcdat),
        .o_left_sample  (left_sample),
        .o_right_sample (right_sample),
        .o_sample_out   (sample_out),
        .o_sample_valid (sample_valid),
        .o_frame_err    (frame_err),
        .o_err_count    (err_count)
    );

    initial forever #10 clk = ~clk;

    // Observe outputs just after each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (sample_valid === 1'b1) begin
            q_l.push_back(left_sample);
            q_r.push_back(right_sample);
            q_o.push_back(sample_out);
            q_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) n_err_pulse++;
    end

    function automatic logic [15:0] exp_mono(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_RX_MONO_MIX_EN
        int s;
        s = int'($signed(l)) + int'($signed(r));
        if (s >= 0) return 16'(s / 2);
        return 16'(-((1 - s) / 2));
`else
        return l + 16'(0 * r);
`endif
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic clear_q();
        q_l.delete();
        q_r.delete();
        q_o.delete();
        q_cyc.delete();
    endtask

    // One bclk period: lrck and data change with the falling edge, rise half a period later
    task automatic bclk_cycle(input logic lr, input logic d);
        @(negedge clk);
        aud_bclk = 1'b0;
        aud_adclrck = lr;
        aud_adcdat = d;
        repeat (half - 1) @(negedge clk);
        @(negedge clk);
        aud_bclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (half - 1) @(negedge clk);
    endtask

    // Slot: period 0 is the I2S delay bit, periods 1..16 carry the word MSB first
    task automatic send_slot(input logic lr, input logic [15:0] w, input int ncyc, output int lsb_cyc);
        logic d;
        lsb_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (c >= 1 && c <= 16) d = w[16 - c];
            else d = 1'($urandom);
            bclk_cycle(lr, d);
            if (c == 16) lsb_cyc = last_rise_cyc;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, output int rlsb);
        int dummy;
        send_slot(1'b0, l, 32, dummy);
        send_slot(1'b1, r, 32, rlsb);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (left_sample !== 16'h0) begin fails++; $display("FAIL reset_left: got %h want 0000", left_sample); end
        tests_run++; if (right_sample !== 16'h0) begin fails++; $display("FAIL reset_right: got %h want 0000", right_sample); end
        tests_run++; if (sample_out !== 16'h0) begin fails++; $display("FAIL reset_out: got %h want 0000", sample_out); end
        tests_run++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        tests_run++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", frame_err); end
        tests_run++; if (err_count !== 8'h0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", err_count); end
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int rlsb;
        half = 8;
        clear_q();
        send_frame(16'h8001, 16'h7FFE, rlsb);
        tests_run++;
        if (q_l.size() != 1) begin
            fails++; $display("FAIL single_count: got %0d valid pulses want 1", q_l.size());
        end else begin
            tests_run++; if (q_l[0] !== 16'h8001) begin fails++; $display("FAIL single_left: got %h want 8001", q_l[0]); end
            tests_run++; if (q_r[0] !== 16'h7FFE) begin fails++; $display("FAIL single_right: got %h want 7ffe", q_r[0]); end
            tests_run++; if (q_o[0] !== exp_mono(16'h8001, 16'h7FFE)) begin fails++; $display("FAIL single_out: got %h want %h", q_o[0], exp_mono(16'h8001, 16'h7FFE)); end
            // bclk_rise visible 2 clk after the pin, valid one clk later
            tests_run++; if (q_cyc[0] != rlsb + 3) begin fails++; $display("FAIL single_latency: got cycle %0d want %0d", q_cyc[0], rlsb + 3); end
        end
        tests_run++; if (left_sample !== 16'h8001) begin fails++; $display("FAIL single_hold: got %h want 8001", left_sample); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] el[$];
        logic [15:0] er[$];
        int          ec[$];
        logic [15:0] base, l, r;
        int          e0, rlsb;
        half = 3;
        clear_q();
        e0 = n_err_pulse;
        base = 16'($urandom);
        for (int i = 0; i < 100; i++) begin
            l = base + 16'(i);
            r = 16'($urandom);
            el.push_back(l);
            er.push_back(r);
            send_frame(l, r, rlsb);
            ec.push_back(rlsb + 3);
        end
        tests_run++;
        if (q_l.size() != 100) begin
            fails++; $display("FAIL b2b_count: got %0d valid pulses want 100", q_l.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                tests_run++; if (q_l[i] !== el[i]) begin fails++; $display("FAIL b2b_left[%0d]: got %h want %h", i, q_l[i], el[i]); end
                tests_run++; if (q_r[i] !== er[i]) begin fails++; $display("FAIL b2b_right[%0d]: got %h want %h", i, q_r[i], er[i]); end
                tests_run++; if (q_o[i] !== exp_mono(el[i], er[i])) begin fails++; $display("FAIL b2b_out[%0d]: got %h want %h", i, q_o[i], exp_mono(el[i], er[i])); end
                tests_run++; if (q_cyc[i] != ec[i]) begin fails++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, q_cyc[i], ec[i]); end
                if (i > 0) begin
                    tests_run++; if (q_cyc[i] - q_cyc[i-1] != 128 * half) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, q_cyc[i] - q_cyc[i-1], 128 * half); end
                end
            end
        end
        tests_run++; if (n_err_pulse != e0) begin fails++; $display("FAIL b2b_frame_err: got %0d pulses want 0", n_err_pulse - e0); end
    endtask

    task automatic test_frame_error();
        logic [15:0] l, r;
        int          e0, d, rlsb;
        half = 8;
        clear_q();
        e0 = n_err_pulse;
        send_slot(1'b0, 16'($urandom), 10, d);
        send_slot(1'b1, 16'($urandom), 32, d);
        exp_err = sat_inc(exp_err);
        tests_run++; if (n_err_pulse - e0 != 1) begin fails++; $display("FAIL ferr_pulse: got %0d pulses want 1", n_err_pulse - e0); end
        tests_run++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL ferr_count: got %0d want %0d", err_count, exp_err); end
        tests_run++; if (q_l.size() != 0) begin fails++; $display("FAIL ferr_novalid: got %0d pulses want 0", q_l.size()); end
        l = 16'($urandom);
        r = 16'($urandom);
        send_frame(l, r, rlsb);
        tests_run++;
        if (q_l.size() != 1) begin
            fails++; $display("FAIL ferr_recover_count: got %0d want 1", q_l.size());
        end else begin
            tests_run++; if (q_l[0] !== l || q_r[0] !== r) begin fails++; $display("FAIL ferr_recover_data: got %h/%h want %h/%h", q_l[0], q_r[0], l, r); end
        end
        tests_run++; if (n_err_pulse - e0 != 1) begin fails++; $display("FAIL ferr_recover_err: got %0d pulses want 1", n_err_pulse - e0); end
    endtask

    task automatic test_enable_drop();
        logic [15:0] l, r;
        int          e0, d, rlsb;
        half = 8;
        clear_q();
        e0 = n_err_pulse;
        send_slot(1'b0, 16'($urandom), 32, d);
        send_slot(1'b1, 16'($urandom), 6, d);
        enable = 1'b0;
        send_slot(1'b1, 16'($urandom), 26, d);
        tests_run++; if (q_l.size() != 0) begin fails++; $display("FAIL en_novalid: got %0d pulses want 0", q_l.size()); end
        enable = 1'b1;
        l = 16'($urandom);
        r = 16'($urandom);
        send_frame(l, r, rlsb);
        tests_run++;
        if (q_l.size() != 1) begin
            fails++; $display("FAIL en_resume_count: got %0d want 1", q_l.size());
        end else begin
            tests_run++; if (q_l[0] !== l || q_r[0] !== r) begin fails++; $display("FAIL en_resume_data: got %h/%h want %h/%h", q_l[0], q_r[0], l, r); end
            tests_run++; if (q_o[0] !== exp_mono(l, r)) begin fails++; $display("FAIL en_resume_out: got %h want %h", q_o[0], exp_mono(l, r)); end
        end
        tests_run++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL en_err_count: got %0d want %0d", err_count, exp_err); end
        tests_run++; if (n_err_pulse != e0) begin fails++; $display("FAIL en_err_pulse: got %0d pulses want 0", n_err_pulse - e0); end
    endtask

    task automatic test_saturation();
        int e0, d;
        half = 3;
        clear_q();
        e0 = n_err_pulse;
        for (int i = 0; i < 300; i++) begin
            send_slot(1'b0, 16'($urandom), 3, d);
            send_slot(1'b1, 16'($urandom), 1, d);
            exp_err = sat_inc(exp_err);
            if (i == 99) begin
                tests_run++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL sat_mid_count: got %0d want %0d", err_count, exp_err); end
            end
        end
        tests_run++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL sat_count: got %0d want %0d", err_count, exp_err); end
        tests_run++; if (n_err_pulse - e0 != 300) begin fails++; $display("FAIL sat_pulses: got %0d want 300", n_err_pulse - e0); end
        tests_run++; if (q_l.size() != 0) begin fails++; $display("FAIL sat_novalid: got %0d pulses want 0", q_l.size()); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] l, r;
        int          d, rlsb;
        half = 8;
        clear_q();
        send_slot(1'b0, 16'($urandom), 6, d);
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        tests_run++; if (left_sample !== 16'h0 || right_sample !== 16'h0 || sample_out !== 16'h0) begin fails++; $display("FAIL rstmid_samples: got %h/%h/%h want 0", left_sample, right_sample, sample_out); end
        tests_run++; if (err_count !== 8'h0 || sample_valid !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_status: got cnt %0d valid %b err %b want 0", err_count, sample_valid, frame_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_slot(1'b0, 16'($urandom), 26, d);
        send_slot(1'b1, 16'($urandom), 32, d);
        tests_run++; if (q_l.size() != 0) begin fails++; $display("FAIL rstmid_novalid: got %0d want 0", q_l.size()); end
        l = 16'($urandom);
        r = 16'($urandom);
        send_frame(l, r, rlsb);
        tests_run++;
        if (q_l.size() != 1) begin
            fails++; $display("FAIL rstmid_count: got %0d want 1", q_l.size());
        end else begin
            tests_run++; if (q_l[0] !== l || q_r[0] !== r) begin fails++; $display("FAIL rstmid_data: got %h/%h want %h/%h", q_l[0], q_r[0], l, r); end
            tests_run++; if (q_cyc[0] != rlsb + 3) begin fails++; $display("FAIL rstmid_latency: got %0d want %0d", q_cyc[0], rlsb + 3); end
        end
        tests_run++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL rstmid_err_count: got %0d want %0d", err_count, exp_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_error();
        test_enable_drop();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
